// File: rtl/gfx_fixed_pkg.sv
// Fixed-point types and arithmetic helpers for the geometry path.
// Build option: define VERTEX_XFORM_SATURATE_EN to clamp products and sums
// to the signed range instead of wrapping.
package gfx_fixed_pkg;

  localparam int unsigned FxDataW = 32;
  localparam int unsigned FxFracW = 16;

  typedef logic signed [FxDataW-1:0]   fixed_t;
  typedef logic signed [2*FxDataW-1:0] wide_t;

  // 1.0 in Q(DataW-FracW).FracW
  localparam fixed_t FxOne = fixed_t'(1 << FxFracW);

  typedef enum logic [1:0] {StIdle, StRun, StOut} xform_state_e;

  function automatic wide_t fx_widen(input fixed_t a);
    return {{FxDataW{a[FxDataW-1]}}, a};
  endfunction

  // Narrow a double-width intermediate back to fixed_t (wrap or clamp).
  function automatic fixed_t fx_sat(input wide_t v);
`ifdef VERTEX_XFORM_SATURATE_EN
    wide_t wmax;
    wide_t wmin;
    wmax = {{(FxDataW + 1){1'b0}}, {(FxDataW - 1){1'b1}}};
    wmin = {{(FxDataW + 1){1'b1}}, {(FxDataW - 1){1'b0}}};
    if (v > wmax) begin
      return fixed_t'(wmax);
    end else if (v < wmin) begin
      return fixed_t'(wmin);
    end else begin
      return fixed_t'(v);
    end
`else
    return fixed_t'(v);
`endif
  endfunction

  // Full-width signed product, arithmetic shift (floor), then narrow.
  function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
    wide_t prod;
    prod = fx_widen(a) * fx_widen(b);
    return fx_sat(prod >>> FxFracW);
  endfunction

  function automatic fixed_t fx_add(input fixed_t a, input fixed_t b);
    return fx_sat(fx_widen(a) + fx_widen(b));
  endfunction

endpackage

// File: rtl/fx_dot4.sv
// Two-stage registered 4-term fixed-point dot product with a valid bit.
// Stage 1 registers the four products, stage 2 registers their sum.
module fx_dot4
  import gfx_fixed_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_i,
  input  fixed_t [3:0] row_i,
  input  fixed_t [3:0] vec_i,
  output fixed_t       dot_o,
  output logic         valid_o
);

  fixed_t [3:0] prod_q;
  logic         prod_vld_q;
  fixed_t       sum_q;
  logic         sum_vld_q;
  fixed_t       sum_d;

  // Stage 1: register the four products of the current vertex.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= valid_i;
      if (valid_i) begin
        for (int c = 0; c < 4; c++) begin
          prod_q[c] <= fx_mul(row_i[c], vec_i[c]);
        end
      end
    end
  end

  // Sum at double width so the single narrowing step wraps or clamps once.
  always_comb begin
    wide_t acc;
    acc = '0;
    for (int c = 0; c < 4; c++) begin
      acc = acc + fx_widen(prod_q[c]);
    end
    sum_d = fx_sat(acc);
  end

  // Stage 2: register the row sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      sum_vld_q <= prod_vld_q;
      if (prod_vld_q) begin
        sum_q <= sum_d;
      end
    end
  end

  assign dot_o   = sum_q;
  assign valid_o = sum_vld_q;

endmodule

// File: rtl/vertex_xform_pipe.sv
// Pipelined 4x4 fixed-point vertex transform with optional viewport mapping.
// Accepts one primitive + matrix, streams vertices one per cycle through
// multiply / sum / viewport stages, then holds the result until taken.
// Build option: VERTEX_XFORM_SATURATE_EN (clamping arithmetic, see gfx_fixed_pkg).
// DATA_W / FRAC_W must match the widths fixed in gfx_fixed_pkg.
module vertex_xform_pipe
  import gfx_fixed_pkg::*;
#(
  parameter int unsigned DATA_W    = FxDataW,
  parameter int unsigned FRAC_W    = FxFracW,
  parameter int unsigned NUM_VERTS = 3,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [15:0][DATA_W-1:0]              mat_i,
  input  logic [NUM_VERTS-1:0][2:0][DATA_W-1:0] v_in_i,
  input  logic                                 viewport_en_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [NUM_VERTS-1:0][DATA_W-1:0]     x_out_o,
  output logic [NUM_VERTS-1:0][DATA_W-1:0]     y_out_o,
  output logic [NUM_VERTS-1:0][DATA_W-1:0]     z_out_o,
  output logic [NUM_VERTS-1:0][DATA_W-1:0]     w_out_o,
  output logic                                 busy_o
);

  localparam int unsigned CntW  = $clog2(NUM_VERTS + 1);
  localparam fixed_t      HalfW = fixed_t'((SCREEN_W / 2) << FRAC_W);
  localparam fixed_t      HalfH = fixed_t'((SCREEN_H / 2) << FRAC_W);

  xform_state_e state_q, state_d;

  fixed_t [15:0]                mat_q;
  fixed_t [NUM_VERTS-1:0][2:0]  v_q;
  logic                         vp_q;
  logic [CntW-1:0]              issue_cnt_q;
  logic [CntW-1:0]              wr_cnt_q;

  fixed_t [NUM_VERTS-1:0] x_q, y_q, z_q, w_q;

  logic         accept;
  logic         issue_vld;
  fixed_t [3:0] vec;
  fixed_t [3:0] dot;
  logic   [3:0] dot_vld;
  logic         stage_vld;
  fixed_t       x_map, y_map;

  assign accept    = in_valid_i && (state_q == StIdle);
  assign issue_vld = (state_q == StRun) && (issue_cnt_q < CntW'(NUM_VERTS));
  // All four rows advance in lockstep; AND keeps every valid observed.
  assign stage_vld = &dot_vld;

  // Select the vertex being issued; column 3 is the homogeneous w = 1.0.
  always_comb begin
    vec    = '0;
    vec[3] = FxOne;
    for (int i = 0; i < int'(NUM_VERTS); i++) begin
      if (issue_cnt_q == CntW'(i)) begin
        vec[2:0] = v_q[i];
      end
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    fx_dot4 u_dot (
      .clock   (clock),
      .reset   (reset),
      .valid_i (issue_vld),
      .row_i   (mat_q[r*4 +: 4]),
      .vec_i   (vec),
      .dot_o   (dot[r]),
      .valid_o (dot_vld[r])
    );
  end

  // Stage 3 viewport mapping on x,y; z,w pass straight through.
  always_comb begin
    x_map = dot[0];
    y_map = dot[1];
    if (vp_q) begin
      x_map = fx_add(fx_mul(dot[0], HalfW), HalfW);
      y_map = fx_add(fx_mul(dot[1], HalfH), HalfH);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) state_d = StRun;
      end
      StRun: begin
        if (stage_vld && (wr_cnt_q == CntW'(NUM_VERTS - 1))) state_d = StOut;
      end
      StOut: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Input capture and issue / write-slot counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mat_q       <= '0;
      v_q         <= '0;
      vp_q        <= 1'b0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else if (accept) begin
      mat_q       <= mat_i;
      v_q         <= v_in_i;
      vp_q        <= viewport_en_i;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (issue_vld) issue_cnt_q <= issue_cnt_q + 1'b1;
      if (stage_vld) wr_cnt_q    <= wr_cnt_q + 1'b1;
    end
  end

  // Stage 3: write the finished vertex into its output slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      w_q <= '0;
    end else if (stage_vld) begin
      for (int i = 0; i < int'(NUM_VERTS); i++) begin
        if (wr_cnt_q == CntW'(i)) begin
          x_q[i] <= x_map;
          y_q[i] <= y_map;
          z_q[i] <= dot[2];
          w_q[i] <= dot[3];
        end
      end
    end
  end

  assign x_out_o = x_q;
  assign y_out_o = y_q;
  assign z_out_o = z_q;
  assign w_out_o = w_q;

endmodule

// File: tb/tb_vertex_xform_pipe.sv
// Directed table-driven bench for vertex_xform_pipe (default parameters).
module tb_vertex_xform_pipe;

  localparam int          N   = 3;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [15:0][31:0]      mat = '0;
  logic [N-1:0][2:0][31:0] v_in = '0;
  logic                   viewport_en = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [N-1:0][31:0]     x_out, y_out, z_out, w_out;
  logic                   busy;

  vertex_xform_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .mat_i         (mat),
    .v_in_i        (v_in),
    .viewport_en_i (viewport_en),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .x_out_o       (x_out),
    .y_out_o       (y_out),
    .z_out_o       (z_out),
    .w_out_o       (w_out),
    .busy_o        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0][31:0]       mat;
    logic [N-1:0][2:0][31:0] v;
    logic                    vp;
    logic [N-1:0][31:0]      ex, ey, ez, ew;
  } vec_t;

  vec_t tbl[5];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept a primitive, time the result, compare all slots, then drain it.
  task automatic run_vec(input vec_t t, input string tag);
    int lat;
    mat         = t.mat;
    v_in        = t.v;
    viewport_en = t.vp;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid    = 1'b0;
    mat         = {16{32'hDEAD_BEEF}};
    v_in        = {(N * 3){32'hBAAD_F00D}};
    viewport_en = ~t.vp;
    check({tag, " busy run"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s x%0d", tag, i), x_out[i], t.ex[i]);
      check($sformatf("%s y%0d", tag, i), y_out[i], t.ey[i]);
      check($sformatf("%s z%0d", tag, i), z_out[i], t.ez[i]);
      check($sformatf("%s w%0d", tag, i), w_out[i], t.ew[i]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Common defaults: identity matrix, zero vertices, w = 1.0 everywhere.
    for (int i = 0; i < 5; i++) begin
      tbl[i].mat     = '0;
      tbl[i].mat[0]  = ONE;
      tbl[i].mat[5]  = ONE;
      tbl[i].mat[10] = ONE;
      tbl[i].mat[15] = ONE;
      tbl[i].v       = '0;
      tbl[i].vp      = 1'b0;
      tbl[i].ex      = '0;
      tbl[i].ey      = '0;
      tbl[i].ez      = '0;
      tbl[i].ew      = {N{ONE}};
    end
    // 0: identity pass-through
    tbl[0].v[0][0] = 32'h0001_0000; tbl[0].v[0][1] = 32'h0000_8000; tbl[0].v[0][2] = 32'hFFFF_C000;
    tbl[0].v[1][0] = 32'h0002_0000; tbl[0].v[1][1] = 32'h0003_0000; tbl[0].v[1][2] = 32'hFFFF_0000;
    tbl[0].ex[0] = 32'h0001_0000; tbl[0].ey[0] = 32'h0000_8000; tbl[0].ez[0] = 32'hFFFF_C000;
    tbl[0].ex[1] = 32'h0002_0000; tbl[0].ey[1] = 32'h0003_0000; tbl[0].ez[1] = 32'hFFFF_0000;
    // 1: same vertices through the 640x480 viewport
    tbl[1]       = tbl[0];
    tbl[1].vp    = 1'b1;
    tbl[1].ex[0] = 32'h0280_0000; tbl[1].ey[0] = 32'h0168_0000;
    tbl[1].ex[1] = 32'h03C0_0000; tbl[1].ey[1] = 32'h03C0_0000;
    tbl[1].ex[2] = 32'h0140_0000; tbl[1].ey[2] = 32'h00F0_0000;
    // 2: translate x by +2.0, distinct vertices per slot
    tbl[2].mat[3]  = 32'h0002_0000;
    tbl[2].v[0][0] = 32'h0001_0000; tbl[2].v[0][1] = 32'h0002_0000; tbl[2].v[0][2] = 32'h0003_0000;
    tbl[2].v[1][0] = 32'hFFFF_0000; tbl[2].v[1][1] = 32'h0005_0000; tbl[2].v[1][2] = 32'h0006_0000;
    tbl[2].v[2][0] = 32'h0007_0000;
    tbl[2].ex[0] = 32'h0003_0000; tbl[2].ey[0] = 32'h0002_0000; tbl[2].ez[0] = 32'h0003_0000;
    tbl[2].ex[1] = 32'h0001_0000; tbl[2].ey[1] = 32'h0005_0000; tbl[2].ez[1] = 32'h0006_0000;
    tbl[2].ex[2] = 32'h0009_0000;
    // 3: scale x by 0.5, y by 2.0; checks floor rounding of negatives
    tbl[3].mat[0]  = 32'h0000_8000;
    tbl[3].mat[5]  = 32'h0002_0000;
    tbl[3].v[0][0] = 32'hFFFF_FFFF; tbl[3].v[0][1] = 32'h0001_8000;
    tbl[3].v[1][0] = 32'h0000_0001; tbl[3].v[1][1] = 32'hFFFF_8000; tbl[3].v[1][2] = 32'h0005_0000;
    tbl[3].v[2][0] = 32'h0004_0000;
    tbl[3].ex[0] = 32'hFFFF_FFFF; tbl[3].ey[0] = 32'h0003_0000;
    tbl[3].ex[1] = 32'h0000_0000; tbl[3].ey[1] = 32'hFFFF_0000; tbl[3].ez[1] = 32'h0005_0000;
    tbl[3].ex[2] = 32'h0002_0000;
    // 4: product overflow, wraps or clamps depending on build
    tbl[4].mat[0]  = 32'h7FFF_0000;
    tbl[4].v[0][0] = 32'h0002_0000;
    tbl[4].v[2][0] = 32'h0001_0000;
`ifdef VERTEX_XFORM_SATURATE_EN
    tbl[4].ex[0] = 32'h7FFF_FFFF;
`else
    tbl[4].ex[0] = 32'hFFFE_0000;
`endif
    tbl[4].ex[2] = 32'h7FFF_0000;

    // Reset state
    #2;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset x0", x_out[0], 32'd0);
    check("reset w2", w_out[2], 32'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low while upstream keeps offering junk.
    mat         = tbl[0].mat;
    v_in        = tbl[0].v;
    viewport_en = 1'b0;
    in_valid    = 1'b1;
    tick();
    mat  = {16{32'h1234_5678}};
    v_in = {(N * 3){32'h0BAD_0BAD}};
    for (int k = 0; k < 5 && !out_valid; k++) tick();
    check("bp out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp hold x1 c%0d", k), x_out[1], tbl[0].ex[1]);
      check($sformatf("bp hold rdy c%0d", k), {31'd0, in_ready, 1'b0} | 32'(out_valid),
            32'd1);
    end
    check("bp z0", z_out[0], tbl[0].ez[0]);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp released valid", 32'(out_valid), 32'd0);
    check("bp released ready", 32'(in_ready), 32'd1);
    tick();
    check("bp single transfer busy", 32'(busy), 32'd0);

    // Reset in the middle of RUN, then a fresh primitive must come out clean.
    mat      = tbl[2].mat;
    v_in     = tbl[2].v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst x0", x_out[0], 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_vec(tbl[3], "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
